riscv_mem_arbiter: RTL and testbench

- Arbitrates the single shared instruction/data memory between two requesters:
  - the multi-cycle core (fetch, load and store traffic, already address-muxed by the core).
  - a program-loader/DMA port that fills or reads memory while the core runs.
- Sits between the core memory port and the memory block.
- Sequences each access as a two-phase ISSUE/RESP transaction and gives the core a stall indication.

---
 rtl/riscv_mem_pkg.sv | 14 +
 rtl/riscv_rr_arb2.sv | 83 ++++++++
 rtl/riscv_mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types for the core/DMA memory arbiter.
// Transaction states and owner encodings.
package riscv_mem_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_e;

   localparam logic OWN_CORE = 1'b0;
   localparam logic OWN_DMA  = 1'b1;

endpackage

// File: rtl/riscv_rr_arb2.sv
// Two-way round-robin pick between core and DMA with a DMA lock/burst override.
// Holds last_owner and burst count; the pick itself is combinational.
module riscv_rr_arb2
   import riscv_mem_pkg::*;
#(
   parameter int MAX_BURST = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic idle_i,
   input  logic resp_i,
   input  logic c_req_i,
   input  logic d_req_i,
   input  logic d_lock_i,
   output logic gnt_vld_o,
   output logic gnt_own_o
);

   localparam int BW = $clog2(MAX_BURST + 1);

   logic          last_q;
   logic          last_d;
   logic [BW-1:0] burst_q;
   logic [BW-1:0] burst_d;
   logic          lock_ok;
   logic          locked;

   assign lock_ok = (last_q == OWN_DMA) && d_lock_i &&
                    (burst_q < BW'(MAX_BURST));

   always_comb begin
      gnt_vld_o = 1'b0;
      gnt_own_o = OWN_CORE;
      locked    = 1'b0;
      unique case (1'b1)
         idle_i: begin
            if (c_req_i && d_req_i) begin
               gnt_vld_o = 1'b1;
               locked    = lock_ok;
               gnt_own_o = lock_ok ? OWN_DMA : ~last_q;
            end else if (c_req_i || d_req_i) begin
               gnt_vld_o = 1'b1;
               gnt_own_o = d_req_i ? OWN_DMA : OWN_CORE;
            end
         end
         resp_i: begin
            // Owner just got its ack; only the other side may be granted.
            // A locked DMA holds the core off so it can re-request from IDLE.
            if (last_q == OWN_CORE) begin
               gnt_vld_o = d_req_i;
               gnt_own_o = OWN_DMA;
            end else begin
               gnt_vld_o = c_req_i && !lock_ok;
               gnt_own_o = OWN_CORE;
            end
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      burst_d = burst_q;
      if (gnt_vld_o && (gnt_own_o == OWN_CORE))
         burst_d = '0;
      else if (locked)
         burst_d = burst_q + BW'(1);
      else if (!d_lock_i)
         burst_d = '0;
      last_d = gnt_vld_o ? gnt_own_o : last_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_q  <= OWN_DMA;
         burst_q <= '0;
      end else begin
         last_q  <= last_d;
         burst_q <= burst_d;
      end
   end

endmodule

// File: rtl/riscv_mem_arbiter.sv
// Shared memory arbiter: core vs. DMA, two-phase ISSUE/RESP access.
// Registered memory-side outputs and acks; saturating contention counter.
module riscv_mem_arbiter
   import riscv_mem_pkg::*;
#(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int MAX_BURST = 4,
   parameter int CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [DW/8-1:0]   c_be,
   input  logic [AW-1:0]     c_addr,
   input  logic [DW-1:0]     c_wdata,
   output logic [DW-1:0]     c_rdata,
   output logic              c_ack,
   output logic              c_stall,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [DW/8-1:0]   d_be,
   input  logic [AW-1:0]     d_addr,
   input  logic [DW-1:0]     d_wdata,
   input  logic              d_lock,
   output logic [DW-1:0]     d_rdata,
   output logic              d_ack,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_wdata,
   output logic [DW/8-1:0]   mem_be,
   output logic              mem_we,
   input  logic [DW-1:0]     mem_rdata,
   output logic [CNT_W-1:0]  cont_cnt
);

   state_e             state_q;
   logic               owner_q;
   logic               c_ack_q;
   logic               d_ack_q;
   logic               mem_we_q;
   logic [AW-1:0]      mem_addr_q;
   logic [DW-1:0]      mem_wdata_q;
   logic [DW/8-1:0]    mem_be_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_d;

   logic               gnt_vld;
   logic               gnt_own;
   logic               w_we;
   logic [DW/8-1:0]    w_be;
   logic [AW-1:0]      w_addr;
   logic [DW-1:0]      w_wdata;

   riscv_rr_arb2 #(
      .MAX_BURST (MAX_BURST)
   ) u_arb (
      .clk       (clk),
      .rst       (rst),
      .idle_i    (state_q == IDLE),
      .resp_i    (state_q == RESP),
      .c_req_i   (c_req),
      .d_req_i   (d_req),
      .d_lock_i  (d_lock),
      .gnt_vld_o (gnt_vld),
      .gnt_own_o (gnt_own)
   );

   always_comb begin
      w_we    = c_we;
      w_be    = c_be;
      w_addr  = c_addr;
      w_wdata = c_wdata;
      if (gnt_own == OWN_DMA) begin
         w_we    = d_we;
         w_be    = d_be;
         w_addr  = d_addr;
         w_wdata = d_wdata;
      end
   end

   // The memory-side registers double as the latched request copy.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         owner_q     <= OWN_DMA;
         c_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
      end else begin
         c_ack_q  <= 1'b0;
         d_ack_q  <= 1'b0;
         mem_we_q <= 1'b0;
         unique case (state_q)
            IDLE, RESP: begin
               if (gnt_vld) begin
                  state_q     <= ISSUE;
                  owner_q     <= gnt_own;
                  mem_we_q    <= w_we;
                  mem_be_q    <= w_be;
                  mem_addr_q  <= w_addr;
                  mem_wdata_q <= w_wdata;
               end else begin
                  state_q <= IDLE;
               end
            end
            ISSUE: begin
               state_q <= RESP;
               if (owner_q == OWN_CORE)
                  c_ack_q <= 1'b1;
               else
                  d_ack_q <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (c_req && d_req && !(c_ack_q && d_ack_q) && !(&cnt_q))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign c_ack     = c_ack_q;
   assign d_ack     = d_ack_q;
   assign c_stall   = c_req & ~c_ack_q;
   assign c_rdata   = c_ack_q ? mem_rdata : '0;
   assign d_rdata   = d_ack_q ? mem_rdata : '0;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;
   assign cont_cnt  = cnt_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter with a small synchronous-read memory.
module tb_riscv_mem_arbiter;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             c_req = 1'b0, c_we = 1'b0;
   logic [3:0]       c_be = '0;
   logic [AW-1:0]    c_addr = '0;
   logic [DW-1:0]    c_wdata = '0;
   logic [DW-1:0]    c_rdata;
   logic             c_ack, c_stall;
   logic             d_req = 1'b0, d_we = 1'b0, d_lock = 1'b0;
   logic [3:0]       d_be = '0;
   logic [AW-1:0]    d_addr = '0;
   logic [DW-1:0]    d_wdata = '0;
   logic [DW-1:0]    d_rdata;
   logic             d_ack;
   logic [AW-1:0]    mem_addr;
   logic [DW-1:0]    mem_wdata;
   logic [3:0]       mem_be;
   logic             mem_we;
   logic [DW-1:0]    mem_rdata;
   logic [CNT_W-1:0] cont_cnt;

   logic [31:0] mem [0:255];

   int n_chk    = 0;
   int n_err    = 0;
   int both_ack = 0;
   int dack_cnt = 0;

   riscv_mem_arbiter #(
      .AW (AW), .DW (DW), .MAX_BURST (4), .CNT_W (CNT_W)
   ) dut (
      .clk (clk), .rst (rst),
      .c_req (c_req), .c_we (c_we), .c_be (c_be), .c_addr (c_addr),
      .c_wdata (c_wdata), .c_rdata (c_rdata), .c_ack (c_ack),
      .c_stall (c_stall),
      .d_req (d_req), .d_we (d_we), .d_be (d_be), .d_addr (d_addr),
      .d_wdata (d_wdata), .d_lock (d_lock), .d_rdata (d_rdata),
      .d_ack (d_ack),
      .mem_addr (mem_addr), .mem_wdata (mem_wdata), .mem_be (mem_be),
      .mem_we (mem_we), .mem_rdata (mem_rdata), .cont_cnt (cont_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we)
         for (int b = 0; b < 4; b++)
            if (mem_be[b])
               mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      mem_rdata <= mem[mem_addr[9:2]];
   end

   always @(negedge clk) begin
      if (c_ack && d_ack) both_ack++;
      if (d_ack) dack_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      c_req  = 1'b0;
      d_req  = 1'b0;
      d_lock = 1'b0;
      d_we   = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic core_read(input logic [31:0] a, input logic [31:0] exp,
                            input string tag);
      int k;
      c_req  = 1'b1;
      c_we   = 1'b0;
      c_be   = 4'hF;
      c_addr = a;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!c_ack && k < 10);
      chk({tag, "_ack"}, 32'(c_ack), 32'd1);
      chk(tag, c_rdata, exp);
      c_req = 1'b0;
   endtask

   initial begin
      int    base;
      int    n_seq;
      int    pat;
      int    stall_bad;
      bit    started;

      for (int i = 0; i < 256; i++) mem[i] <= '0;
      mem[16] <= 32'h00A00093;

      do_reset();
      chk("rst_cack", 32'(c_ack), 32'd0);
      chk("rst_dack", 32'(d_ack), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_be", 32'(mem_be), 32'd0);
      chk("rst_cnt", 32'(cont_cnt), 32'd0);

      // core-only read
      c_req = 1'b1; c_we = 1'b0; c_be = 4'hF; c_addr = 32'h40;
      @(negedge clk);
      chk("cr_iss_addr", mem_addr, 32'h40);
      chk("cr_iss_stall", 32'(c_stall), 32'd1);
      chk("cr_iss_ack", 32'(c_ack), 32'd0);
      @(negedge clk);
      chk("cr_ack", 32'(c_ack), 32'd1);
      chk("cr_rdata", c_rdata, 32'h00A00093);
      chk("cr_dack", 32'(d_ack), 32'd0);
      chk("cr_stall", 32'(c_stall), 32'd0);
      c_req = 1'b0;
      @(negedge clk);
      chk("cr_ack_pulse", 32'(c_ack), 32'd0);

      // DMA partial write
      d_req = 1'b1; d_we = 1'b1; d_be = 4'b0011;
      d_addr = 32'h100; d_wdata = 32'hDEADBEEF;
      @(negedge clk);
      chk("dw_we", 32'(mem_we), 32'd1);
      chk("dw_be", 32'(mem_be), 32'h3);
      chk("dw_addr", mem_addr, 32'h100);
      chk("dw_wdata", mem_wdata, 32'hDEADBEEF);
      @(negedge clk);
      chk("dw_we_off", 32'(mem_we), 32'd0);
      chk("dw_ack", 32'(d_ack), 32'd1);
      d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      chk("dw_ack_pulse", 32'(d_ack), 32'd0);
      core_read(32'h100, 32'h0000BEEF, "dw_rdback");

      // simultaneous requests after reset
      do_reset();
      c_req = 1'b1; c_addr = 32'h40;
      d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h100;
      @(negedge clk);
      chk("sim_core_first", mem_addr, 32'h40);
      @(negedge clk);
      chk("sim_cack", 32'(c_ack), 32'd1);
      chk("sim_dack0", 32'(d_ack), 32'd0);
      chk("sim_crdata", c_rdata, 32'h00A00093);
      c_req = 1'b0;
      @(negedge clk);
      chk("sim_dma_iss", mem_addr, 32'h100);
      chk("sim_dack1", 32'(d_ack), 32'd0);
      @(negedge clk);
      chk("sim_dack", 32'(d_ack), 32'd1);
      chk("sim_drdata", d_rdata, 32'h0000BEEF);
      d_req = 1'b0;
      @(negedge clk);
      chk("sim_cnt", 32'(cont_cnt), 32'd2);

      // locked DMA burst with the core waiting
      do_reset();
      d_req = 1'b1; d_lock = 1'b1; d_we = 1'b0; d_addr = 32'h40;
      started = 1'b0; n_seq = 0; pat = 0; stall_bad = 0;
      for (int k = 0; k < 80 && n_seq < 6; k++) begin
         @(negedge clk);
         if (started && c_req && !c_ack && !c_stall) stall_bad++;
         if (d_ack) begin
            if (started) begin
               pat = pat * 2;
               n_seq++;
            end else begin
               started = 1'b1;
               c_req   = 1'b1;
               c_addr  = 32'h40;
            end
         end
         if (c_ack) begin
            pat = pat * 2 + 1;
            n_seq++;
            c_req = 1'b0;
         end
      end
      chk("burst_n", 32'(n_seq), 32'd6);
      chk("burst_pat", 32'(pat), 32'b000010);
      chk("burst_stall", 32'(stall_bad), 32'd0);
      d_req = 1'b0; d_lock = 1'b0;

      // reset during ISSUE of a DMA write
      do_reset();
      d_req = 1'b1; d_we = 1'b1; d_be = 4'hF;
      d_addr = 32'h80; d_wdata = 32'h12345678;
      @(negedge clk);
      chk("rs_iss_we", 32'(mem_we), 32'd1);
      base = dack_cnt;
      rst = 1'b1; d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      chk("rs_we_off", 32'(mem_we), 32'd0);
      chk("rs_dack", 32'(d_ack), 32'd0);
      rst = 1'b0;
      core_read(32'h40, 32'h00A00093, "rs_core");
      repeat (2) @(negedge clk);
      chk("rs_no_dack", 32'(dack_cnt - base), 32'd0);
      chk("rs_we_idle", 32'(mem_we), 32'd0);

      // contention counter saturation
      do_reset();
      c_req = 1'b1; c_addr = 32'h40;
      d_req = 1'b1; d_addr = 32'h100;
      repeat (8) @(negedge clk);
      chk("sat_mid", 32'(cont_cnt), 32'd8);
      repeat (17) @(negedge clk);
      chk("sat_cnt", 32'(cont_cnt), 32'd15);
      c_req = 1'b0; d_req = 1'b0;
      repeat (3) @(negedge clk);

      chk("ack_excl", 32'(both_ack), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
